// File: rtl/hrange_stream_pkg.sv
// rtl/hrange_stream_pkg.sv - shared state codes and range/overflow helpers for range generators
package hrange_pkg;

    localparam int MAX_W = 64;

    typedef logic [0:0] state_t;
    localparam state_t IDLE = 1'b0;
    localparam state_t RUN  = 1'b1;

    localparam logic signed [MAX_W-1:0] ZERO = '0;

    // Zero step is never "in range", so a degenerate range cannot loop forever.
    function automatic logic in_range(input logic signed [MAX_W-1:0] x,
                                      input logic signed [MAX_W-1:0] lim,
                                      input logic signed [MAX_W-1:0] stp);
        if (stp > ZERO) begin
            return x < lim;
        end else if (stp < ZERO) begin
            return x > lim;
        end
        return 1'b0;
    endfunction

    // True when x (sign-extended) is representable as a w-bit signed value, w < MAX_W.
    function automatic logic fits_signed(input logic signed [MAX_W-1:0] x, input int w);
        logic signed [MAX_W-1:0] hi;
        hi = x >>> (w - 1);
        return (hi == '0) || (hi == '1);
    endfunction

endpackage

// File: rtl/hrange_stream_if.sv
// rtl/hrange_stream_if.sv - start/config and ready/valid element bundle of the range generator
interface hrange_stream_if #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 16
);
    logic                    _start;
    logic signed [WIDTH-1:0] base;
    logic signed [WIDTH-1:0] limit;
    logic signed [WIDTH-1:0] step;
    logic                    _ready;
    logic                    _valid;
    logic                    _done;
    logic signed [WIDTH-1:0] _0;
    logic [IDX_W-1:0]        _1;

    modport master (
        input  _start, base, limit, step, _ready,
        output _valid, _done, _0, _1
    );

    modport slave (
        output _start, base, limit, step, _ready,
        input  _valid, _done, _0, _1
    );
endinterface

// File: rtl/hrange_stream_step_unit.sv
// rtl/hrange_stream_step_unit.sv - combinational next-value, overflow and continue flag
module hrange_step_unit
    import hrange_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic signed [WIDTH-1:0] cur,
    input  logic signed [WIDTH-1:0] lim,
    input  logic signed [WIDTH-1:0] stp,
    output logic signed [WIDTH-1:0] nxt,
    output logic                    ovf,
    output logic                    cont
);
    logic signed [WIDTH:0] sum;

    // One guard bit so an out-of-range sum is seen instead of wrapping.
    assign sum  = {cur[WIDTH-1], cur} + {stp[WIDTH-1], stp};
    assign nxt  = sum[WIDTH-1:0];
    assign ovf  = !fits_signed(MAX_W'(sum), WIDTH);
    assign cont = !ovf && in_range(MAX_W'(nxt), MAX_W'(lim), MAX_W'(stp));
endmodule

// File: rtl/hrange_stream.sv
// rtl/hrange_stream.sv - range generator emitting base, base+step, ... below/above limit over ready/valid
module hrange_stream
    import hrange_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int IDX_W = 16
) (
    input  logic           _clock,
    input  logic           _reset_n,
    hrange_stream_if.master bus
);
    state_t                  state;
    logic                    valid;
    logic signed [WIDTH-1:0] cur;
    logic signed [WIDTH-1:0] lim_q;
    logic signed [WIDTH-1:0] stp_q;
    logic [IDX_W-1:0]        idx;

    logic signed [WIDTH-1:0] nxt;
    logic                    ovf;
    logic                    cont;
    logic                    start_ok;
    logic                    advance;

    hrange_step_unit #(.WIDTH(WIDTH)) u_step (
        .cur  (cur),
        .lim  (lim_q),
        .stp  (stp_q),
        .nxt  (nxt),
        .ovf  (ovf),
        .cont (cont)
    );

    assign start_ok = in_range(MAX_W'(bus.base), MAX_W'(bus.limit), MAX_W'(bus.step));
    assign advance  = (state == RUN) && (bus._ready || !valid);

    always_ff @(posedge _clock or negedge _reset_n) begin
        if (!_reset_n) begin
            state <= IDLE;
            valid <= 1'b0;
            cur   <= '0;
            lim_q <= '0;
            stp_q <= '0;
            idx   <= '0;
        end else if (bus._start) begin
            // Restart drops any element still waiting for the consumer.
            cur   <= bus.base;
            lim_q <= bus.limit;
            stp_q <= bus.step;
            idx   <= '0;
            valid <= start_ok;
            state <= start_ok ? RUN : IDLE;
        end else if (advance) begin
            if (cont && !(&idx)) begin
                cur   <= nxt;
                idx   <= idx + 1'b1;
                valid <= 1'b1;
            end else begin
                valid <= 1'b0;
                state <= IDLE;
            end
        end
    end

    assign bus._valid = valid;
    assign bus._done  = (state == IDLE);
    assign bus._0     = cur;
    assign bus._1     = idx;
endmodule

// File: tb/tb_hrange_stream.sv
// tb/tb_hrange_stream.sv - scoreboard bench for hrange_stream (8-bit and index-capped instances)
module tb_hrange_stream;

    typedef struct packed {
        logic signed [31:0] v;
        logic [15:0]        idx;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    exp_t               expq [2][$];
    bit                 end_pend [2];
    bit                 stall_prev [2];
    logic signed [31:0] prev_v [2];
    logic [15:0]        prev_i [2];
    int                 xfers [2];

    hrange_stream_if #(.WIDTH(8),  .IDX_W(16)) a ();
    hrange_stream_if #(.WIDTH(32), .IDX_W(2))  b ();

    hrange_stream #(.WIDTH(8), .IDX_W(16)) dut_a (
        ._clock   (clk),
        ._reset_n (rst_n),
        .bus      (a)
    );

    hrange_stream #(.WIDTH(32), .IDX_W(2)) dut_b (
        ._clock   (clk),
        ._reset_n (rst_n),
        .bus      (b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int id, input int v, input int ix);
        exp_t e;
        e.v   = v;
        e.idx = 16'(ix);
        expq[id].push_back(e);
    endtask

    task automatic mon(input int id, input logic v, input logic r, input logic s, input logic d,
                       input logic signed [31:0] val, input logic [15:0] ix);
        exp_t  e;
        string p;
        p = (id == 0) ? "a." : "b.";
        if (!rst_n) begin
            end_pend[id]   = 1'b0;
            stall_prev[id] = 1'b0;
            return;
        end
        if (end_pend[id]) begin
            chk({p, "end_valid"}, longint'(v), 0);
            chk({p, "end_done"}, longint'(d), 1);
            end_pend[id] = 1'b0;
        end
        if (stall_prev[id]) begin
            chk({p, "hold_valid"}, longint'(v), 1);
            chk({p, "hold_0"}, longint'(val), longint'(prev_v[id]));
            chk({p, "hold_1"}, longint'(ix), longint'(prev_i[id]));
        end
        if (v && r && !s) begin
            chk({p, "xfer_expected"}, longint'(expq[id].size() > 0), 1);
            if (expq[id].size() > 0) begin
                e = expq[id].pop_front();
                chk({p, "data_0"}, longint'(val), longint'(e.v));
                chk({p, "data_1"}, longint'(ix), longint'(e.idx));
                xfers[id]++;
                if (expq[id].size() == 0) end_pend[id] = 1'b1;
            end
        end
        stall_prev[id] = v && !r && !s;
        prev_v[id]     = val;
        prev_i[id]     = ix;
    endtask

    always @(negedge clk) begin
        mon(0, a._valid, a._ready, a._start, a._done, 32'(a._0), 16'(a._1));
        mon(1, b._valid, b._ready, b._start, b._done, 32'(b._0), 16'(b._1));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_a(input logic signed [7:0] bs, input logic signed [7:0] lm,
                           input logic signed [7:0] st);
        a.base = bs; a.limit = lm; a.step = st; a._start = 1'b1;
        tick();
        a._start = 1'b0;
    endtask

    task automatic start_b(input int bs, input int lm, input int st);
        b.base = bs; b.limit = lm; b.step = st; b._start = 1'b1;
        tick();
        b._start = 1'b0;
    endtask

    // Drives _ready (1,0,0,1 repeating when bp) until idle with an empty scoreboard.
    task automatic run_idle(input int id, input bit bp, output int cycles);
        int k;
        k = 0;
        cycles = 0;
        while (((id == 0) ? !a._done : !b._done) || expq[id].size() != 0) begin
            if (id == 0) a._ready = bp ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
            else         b._ready = 1'b1;
            tick();
            k++;
            cycles++;
            if (cycles > 200) begin
                chk("run_timeout", cycles, 0);
                expq[id].delete();
                break;
            end
        end
        if (id == 0) a._ready = 1'b1;
        repeat (2) tick();
    endtask

    task automatic check_idle_a(input string name);
        for (int i = 0; i < 3; i++) begin
            chk({name, "_valid"}, longint'(a._valid), 0);
            chk({name, "_done"}, longint'(a._done), 1);
            tick();
        end
    endtask

    initial begin
        int cyc;
        int base_x;
        rst_n = 1'b0;
        a._start = 1'b0; a.base = '0; a.limit = '0; a.step = '0; a._ready = 1'b1;
        b._start = 1'b0; b.base = '0; b.limit = '0; b.step = '0; b._ready = 1'b1;
        repeat (2) tick();
        chk("rst_a_valid", longint'(a._valid), 0);
        chk("rst_a_done", longint'(a._done), 1);
        chk("rst_a_0", longint'(a._0), 0);
        chk("rst_a_1", longint'(a._1), 0);
        chk("rst_b_valid", longint'(b._valid), 0);
        chk("rst_b_done", longint'(b._done), 1);
        rst_n = 1'b1;
        tick();

        // ascending 0..8 step 2, ready held high
        base_x = xfers[0];
        push(0, 0, 0); push(0, 2, 1); push(0, 4, 2); push(0, 6, 3); push(0, 8, 4);
        start_a(0, 10, 2);
        chk("asc_first_valid", longint'(a._valid), 1);
        chk("asc_first_done", longint'(a._done), 0);
        run_idle(0, 1'b0, cyc);
        chk("asc_cycles", cyc, 5);
        chk("asc_xfers", xfers[0] - base_x, 5);

        // descending 5 step -3 down to (excluding) -3
        base_x = xfers[0];
        push(0, 5, 0); push(0, 2, 1); push(0, -1, 2);
        start_a(5, -3, -3);
        run_idle(0, 1'b0, cyc);
        chk("desc_cycles", cyc, 3);
        chk("desc_xfers", xfers[0] - base_x, 3);

        // empty ranges
        start_a(0, 10, 0);
        check_idle_a("zero_step");
        start_a(7, 7, 1);
        check_idle_a("base_eq_limit");

        // backpressure
        base_x = xfers[0];
        push(0, 0, 0); push(0, 1, 1); push(0, 2, 2); push(0, 3, 3); push(0, 4, 4); push(0, 5, 5);
        start_a(0, 6, 1);
        run_idle(0, 1'b1, cyc);
        chk("bp_xfers", xfers[0] - base_x, 6);

        // 8-bit overflow: 130 does not fit
        base_x = xfers[0];
        push(0, 120, 0); push(0, 125, 1);
        start_a(120, 127, 5);
        run_idle(0, 1'b0, cyc);
        chk("ovf_xfers", xfers[0] - base_x, 2);

        // 2-bit index cap
        base_x = xfers[1];
        push(1, 0, 0); push(1, 1, 1); push(1, 2, 2); push(1, 3, 3);
        start_b(0, 100, 1);
        run_idle(1, 1'b0, cyc);
        chk("cap_cycles", cyc, 4);
        chk("cap_xfers", xfers[1] - base_x, 4);

        // restart while element 4 is presented
        push(0, 0, 0); push(0, 2, 1); push(0, 4, 2); push(0, 6, 3); push(0, 8, 4);
        start_a(0, 10, 2);
        repeat (2) tick();
        chk("rs_pre_0", longint'(a._0), 4);
        chk("rs_pre_1", longint'(a._1), 2);
        expq[0].delete();
        base_x = xfers[0];
        push(0, 100, 0); push(0, 101, 1); push(0, 102, 2);
        start_a(100, 103, 1);
        chk("rs_0", longint'(a._0), 100);
        chk("rs_1", longint'(a._1), 0);
        chk("rs_valid", longint'(a._valid), 1);
        run_idle(0, 1'b0, cyc);
        chk("rs_xfers", xfers[0] - base_x, 3);

        // asynchronous reset mid-run
        push(0, 0, 0); push(0, 2, 1); push(0, 4, 2); push(0, 6, 3); push(0, 8, 4);
        start_a(0, 10, 2);
        tick();
        expq[0].delete();
        rst_n = 1'b0;
        #1;
        chk("arst_valid", longint'(a._valid), 0);
        chk("arst_done", longint'(a._done), 1);
        chk("arst_0", longint'(a._0), 0);
        chk("arst_1", longint'(a._1), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check_idle_a("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
